// File: rtl/post_deinterleaver_v1_if.sv
// AXI-Stream style bundle for the post-deinterleaver; tlast exists only when DEINTLV_TLAST_EN is
// defined.
`timescale 1ns/1ps
interface post_deinterleaver_v1_if;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tready;
`ifdef DEINTLV_TLAST_EN
   logic        tlast;
`endif

   modport master (
      output tdata,
      output tvalid,
`ifdef DEINTLV_TLAST_EN
      output tlast,
`endif
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
`ifdef DEINTLV_TLAST_EN
      input  tlast,
`endif
      output tready
   );
endinterface

// File: rtl/post_deinterleaver_v1.sv
// Ping-pong deinterleaver: restores codeword order from a word-major interleaved stream.
// Optional m_axis.tlast per codeword when DEINTLV_TLAST_EN is defined.
`timescale 1ns/1ps
module post_deinterleaver_v1 #(
   parameter int unsigned CODEWORD_SIZE_IN_32 = 65,
   parameter int unsigned NUM_CODEWORDS       = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   post_deinterleaver_v1_if.slave  s_axis,
   post_deinterleaver_v1_if.master m_axis
);
   localparam int unsigned C   = CODEWORD_SIZE_IN_32;
   localparam int unsigned N   = NUM_CODEWORDS;
   localparam int unsigned WW  = $clog2(C);
   localparam int unsigned CWW = $clog2(N);
`ifdef DEINTLV_TLAST_EN
   localparam int unsigned EW  = 33;
`else
   localparam int unsigned EW  = 32;
`endif
   localparam logic [WW-1:0]  WORD_LAST = WW'(C - 1);
   localparam logic [CWW-1:0] CW_LAST   = CWW'(N - 1);

   logic [31:0]    mem [2][N][C];

   logic [1:0]     full_q, full_d;
   logic           wr_pp_q, rd_pp_q, ready_en_q;
   logic [CWW-1:0] wr_cw_q, rd_cw_q;
   logic [WW-1:0]  wr_word_q, rd_word_q;
   logic           inflight_q;
   logic [EW-1:0]  ram_q, rd_entry;
   logic [1:0]     fifo_cnt_q;
   logic [EW-1:0]  slot0_q, slot1_q;
   logic [2:0]     occ;
   logic           wr_fire, wr_last, rd_issue, rd_last, pop;

   assign s_axis.tready = ready_en_q && !full_q[wr_pp_q];
   assign wr_fire       = s_axis.tvalid && s_axis.tready;
   assign wr_last       = wr_fire && (wr_cw_q == CW_LAST) && (wr_word_q == WORD_LAST);

   assign m_axis.tvalid = (fifo_cnt_q != 2'd0);
   assign m_axis.tdata  = slot0_q[31:0];
`ifdef DEINTLV_TLAST_EN
   assign m_axis.tlast  = slot0_q[32];
   assign rd_entry      = {rd_word_q == WORD_LAST, mem[rd_pp_q][rd_cw_q][rd_word_q]};
`else
   assign rd_entry      = mem[rd_pp_q][rd_cw_q][rd_word_q];
`endif
   assign pop           = m_axis.tvalid && m_axis.tready;

   // A same-cycle pop counts as freed space so back-to-back reads sustain 1 word/clk.
   assign occ      = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign rd_issue = full_q[rd_pp_q] && (occ < 3'd2);
   assign rd_last  = rd_issue && (rd_word_q == WORD_LAST) && (rd_cw_q == CW_LAST);

   always_comb begin
      full_d = full_q;
      if (wr_last) full_d[wr_pp_q] = 1'b1;
      if (rd_last) full_d[rd_pp_q] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_pp_q][wr_cw_q][wr_word_q] <= s_axis.tdata;
      if (rd_issue) ram_q <= rd_entry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en_q <= 1'b0;
         full_q     <= '0;
         wr_pp_q    <= 1'b0;
         wr_cw_q    <= '0;
         wr_word_q  <= '0;
      end else begin
         ready_en_q <= 1'b1;
         full_q     <= full_d;
         if (wr_fire) begin
            if (wr_cw_q == CW_LAST) begin
               wr_cw_q <= '0;
               if (wr_word_q == WORD_LAST) begin
                  wr_word_q <= '0;
                  wr_pp_q   <= ~wr_pp_q;
               end else begin
                  wr_word_q <= wr_word_q + 1'b1;
               end
            end else begin
               wr_cw_q <= wr_cw_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pp_q    <= 1'b0;
         rd_cw_q    <= '0;
         rd_word_q  <= '0;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= rd_issue;
         if (rd_issue) begin
            if (rd_word_q == WORD_LAST) begin
               rd_word_q <= '0;
               if (rd_cw_q == CW_LAST) begin
                  rd_cw_q <= '0;
                  rd_pp_q <= ~rd_pp_q;
               end else begin
                  rd_cw_q <= rd_cw_q + 1'b1;
               end
            end else begin
               rd_word_q <= rd_word_q + 1'b1;
            end
         end
      end
   end

   // Two-entry FIFO with slot0 as the registered head driving the output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_cnt_q <= 2'd0;
         slot0_q    <= '0;
         slot1_q    <= '0;
      end else begin
         unique case ({inflight_q, pop})
            2'b10: begin
               if (fifo_cnt_q == 2'd0) slot0_q <= ram_q;
               else                    slot1_q <= ram_q;
               fifo_cnt_q <= fifo_cnt_q + 2'd1;
            end
            2'b01: begin
               slot0_q    <= slot1_q;
               fifo_cnt_q <= fifo_cnt_q - 2'd1;
            end
            2'b11: begin
               if (fifo_cnt_q == 2'd1) begin
                  slot0_q <= ram_q;
               end else begin
                  slot0_q <= slot1_q;
                  slot1_q <= ram_q;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_post_deinterleaver_v1.sv
// Scoreboard bench for post_deinterleaver_v1: random stimulus checked against a block-order model.
`timescale 1ns/1ps
module tb_post_deinterleaver_v1;
`ifdef DEINTLV_TLAST_EN
   localparam int unsigned C = 65, N = 4, RAND_BLOCKS = 4;
`else
   localparam int unsigned C = 3, N = 2, RAND_BLOCKS = 100;
`endif
   localparam int unsigned BW = C * N;
   localparam time P = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #(P / 2) clk = ~clk;

   post_deinterleaver_v1_if s_axis ();
   post_deinterleaver_v1_if m_axis ();

   post_deinterleaver_v1 #(
      .CODEWORD_SIZE_IN_32(C),
      .NUM_CODEWORDS      (N)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s_axis(s_axis),
      .m_axis(m_axis)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] blk[$];
   time         pop_t[$];
   time         t_last_in, t_first_valid;
   int          n_chk = 0, n_pass = 0;
   int          rdy_mode = 0;
   bit          stall = 1'b0;
   logic [31:0] hold_d;
   exp_t        e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
   endtask

   // Word k of a block belongs to codeword k%N at position k/N; emit codewords in order.
   task automatic model_accept(input logic [31:0] d);
      blk.push_back(d);
      if (blk.size() == BW) begin
         for (int cw = 0; cw < N; cw++)
            for (int w = 0; w < C; w++)
               exp_q.push_back('{data: blk[w * N + cw], last: (w == C - 1)});
         blk.delete();
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the handshake edge.
   task automatic send(input logic [31:0] d, input bit gaps, output int waits);
      bit ok = 1'b0;
      waits = 0;
      if (gaps) while ($urandom_range(0, 1) == 1) begin
         @(posedge clk);
         #1;
      end
      s_axis.tdata  = d;
      s_axis.tvalid = 1'b1;
      while (!ok && waits < 5000) begin
         @(negedge clk);
         if (s_axis.tready) ok = 1'b1;
         else begin
            waits++;
            @(posedge clk);
            #1;
         end
      end
      if (ok) begin
         @(posedge clk);
         t_last_in = $time;
         model_accept(d);
         #1;
      end else begin
         chk("send_accept", s_axis.tready, 1);
      end
      s_axis.tvalid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 20000) begin
         @(posedge clk);
         k++;
      end
      chk("drain_empty", 32'(exp_q.size()), 0);
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) m_axis.tready = 1'($urandom_range(0, 1));
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            chk("hold_tvalid", m_axis.tvalid, 1);
            chk("hold_tdata", m_axis.tdata, hold_d);
         end
         if (m_axis.tvalid && t_first_valid == 0) t_first_valid = $time;
         if (m_axis.tvalid && m_axis.tready) begin
            pop_t.push_back($time);
            if (exp_q.size() == 0) begin
               chk("out_expected", 32'(exp_q.size()), 1);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", m_axis.tdata, e.data);
`ifdef DEINTLV_TLAST_EN
               chk("out_tlast", m_axis.tlast, e.last);
`endif
            end
         end
         stall  = m_axis.tvalid && !m_axis.tready;
         hold_d = m_axis.tdata;
      end
   end

   initial begin
      #(P * 90000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w, tot;
      s_axis.tvalid = 1'b0;
      s_axis.tdata  = '0;
      m_axis.tready = 1'b0;
      t_first_valid = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_tready", s_axis.tready, 0);
      chk("rst_m_tvalid", m_axis.tvalid, 0);
      chk("rst_m_tdata", m_axis.tdata, 0);
`ifdef DEINTLV_TLAST_EN
      chk("rst_m_tlast", m_axis.tlast, 0);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("s_tready_after_rst", s_axis.tready, 1);

      // One block back-to-back; first output two edges after the last input handshake.
      m_axis.tready = 1'b1;
      t_first_valid = 0;
      for (int i = 0; i < BW; i++) send(i, 1'b0, w);
      drain();
      chk("latency", 32'(t_first_valid - t_last_in), 32'(2 * P + P / 2));

      // Two blocks continuous: no input stalls, output one word per clock.
      pop_t.delete();
      tot = 0;
      for (int i = 0; i < 2 * BW; i++) begin
         send(i, 1'b0, w);
         tot += w;
      end
      drain();
      chk("b2b_input_stalls", tot, 0);
      chk("sustained_output", 32'(pop_t[2 * BW - 1] - pop_t[0]), 32'((2 * BW - 1) * P));

      // Output stalled: both banks fill, then input blocks until release.
      m_axis.tready = 1'b0;
      for (int i = 0; i < 2 * BW; i++) send(i, 1'b0, w);
      s_axis.tdata  = 2 * BW;
      s_axis.tvalid = 1'b1;
      repeat (20) @(negedge clk);
      chk("both_full_tready", s_axis.tready, 0);
      @(posedge clk);
      #1;
      m_axis.tready = 1'b1;
      for (int i = 2 * BW; i < 3 * BW; i++) send(i, 1'b0, w);
      drain();

      // Random valid gaps and output back-pressure.
      rdy_mode = 1;
      for (int b = 0; b < RAND_BLOCKS; b++)
         for (int i = 0; i < BW; i++) send($urandom, 1'b1, w);
      drain();
      rdy_mode = 0;
      m_axis.tready = 1'b1;

      // Reset mid-block discards the partial block.
      for (int i = 0; i < 4; i++) send(32'hA000 + i, 1'b0, w);
      rst_n = 1'b0;
      blk.delete();
      exp_q.delete();
      #1;
      chk("midrst_s_tready", s_axis.tready, 0);
      chk("midrst_m_tvalid", m_axis.tvalid, 0);
      chk("midrst_m_tdata", m_axis.tdata, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < BW; i++) send(i, 1'b0, w);
      drain();
      chk("blk_model_empty", 32'(blk.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
